// File: rtl/sva_seq_pkg.sv
// Shared types for the c/b sequence generator and the sequence checker it drives.
package sva_seq_pkg;

  // Checker state encoding, shared with the checker so the expected values compare directly.
  typedef enum int {
    S0    = 0,
    S1    = 1,
    SEND  = -1,
    SLAZY = -2
  } sva_fsm_t;

  typedef enum logic [1:0] {
    PASS_DIRECT = 2'd0,
    PASS_CHAIN  = 2'd1,
    FAIL_INJECT = 2'd2,
    PASS_RAND   = 2'd3
  } gen_mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHAIN = 3'd1,
    CLOSE = 3'd2,
    ABORT = 3'd3,
    DONE  = 3'd4
  } gen_state_t;

  // One stimulus vector together with the checker state it should produce.
  typedef struct packed {
    logic        c;
    logic        b;
    logic        viol;
    logic [31:0] st;
  } vec_t;

  // Vector for a chain or closing slot; a violating slot is always !c&!b and returns the checker to S0.
  function automatic vec_t make_vec(input gen_mode_t mode, input logic is_close, input logic hit);
    vec_t v;
    if (hit) begin
      v = '{c: 1'b0, b: 1'b0, viol: 1'b1, st: 32'(S0)};
    end else if (is_close) begin
      if (mode == PASS_DIRECT) v = '{c: 1'b0, b: 1'b1, viol: 1'b0, st: 32'(SEND)};
      else                     v = '{c: 1'b1, b: 1'b1, viol: 1'b0, st: 32'(SEND)};
    end else begin
      v = '{c: 1'b1, b: 1'b0, viol: 1'b0, st: 32'(S1)};
    end
    return v;
  endfunction

endpackage

// File: rtl/sva_lfsr.sv
// Galois LFSR used to draw random chain lengths; exposes its low VAL_W bits.
module sva_lfsr #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter int                VAL_W     = LFSR_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [VAL_W-1:0]  value
);

  logic [LFSR_W-1:0] lfsr_q;

  // Seed load wins over advance; an all-zero seed would lock the register, so it becomes 1.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lfsr_q <= LFSR_W'(1);
    end else if (load) begin
      lfsr_q <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (advance) begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end
  end

  assign value = lfsr_q[VAL_W-1:0];

endmodule

// File: rtl/sva_seq_gen.sv
// Stimulus generator for the c/b sequence checker: one vector per step pulse plus expected verdicts.
module sva_seq_gen
  import sva_seq_pkg::*;
#(
  parameter int                LEN_W     = 4,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  len,
  input  logic [LEN_W-1:0]  fail_at,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic              busy,
  output logic              vld,
  output logic              c,
  output logic              b,
  output logic [31:0]       exp_state,
  output logic              exp_succ,
  output logic              exp_fail,
  output logic              done
);

  gen_state_t       state;
  gen_mode_t        mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] fail_q;
  logic [LEN_W-1:0] step_cnt;
  logic             viol_q;
  logic [LEN_W-1:0] lfsr_value;

  gen_mode_t        start_mode;
  logic [LEN_W-1:0] start_len;
  logic             start_close;
  vec_t             start_vec;
  logic [LEN_W-1:0] cnt_nxt;
  logic             close_nxt;
  vec_t             next_vec;

  wire is_idle = (state == IDLE);

  sva_lfsr #(
    .LFSR_W   (LFSR_W),
    .LFSR_TAPS(LFSR_TAPS),
    .VAL_W    (LEN_W)
  ) u_lfsr (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .load   (seed_load & is_idle),
    .seed   (seed),
    .advance(start & is_idle & (gen_mode_t'(mode) == PASS_RAND)),
    .value  (lfsr_value)
  );

  // First vector of a new sequence and the vector following a chain step.
  // NOTE: every signal assigned here gets a value on every path first, otherwise a latch is inferred.
  always_comb begin
    start_mode  = gen_mode_t'(mode);
    start_len   = (start_mode == PASS_RAND) ? lfsr_value : len;
    start_close = (start_mode == PASS_DIRECT) || (start_len == '0);
    start_vec   = make_vec(start_mode, start_close,
                           (start_mode == FAIL_INJECT) &&
                           (start_close ? (fail_at >= start_len) : (fail_at == '0)));
    // Chain steps stop on equality, so the counter can never run past len and wrap.
    cnt_nxt     = step_cnt + LEN_W'(1);
    close_nxt   = (cnt_nxt == len_q);
    next_vec    = make_vec(mode_q, close_nxt,
                           (mode_q == FAIL_INJECT) &&
                           (close_nxt ? (fail_q >= len_q) : (fail_q == cnt_nxt)));
  end

  // Sequencer FSM with registered vector, expected-state and pulse outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      mode_q    <= PASS_DIRECT;
      len_q     <= '0;
      fail_q    <= '0;
      step_cnt  <= '0;
      viol_q    <= 1'b0;
      busy      <= 1'b0;
      vld       <= 1'b0;
      c         <= 1'b0;
      b         <= 1'b0;
      exp_state <= 32'(S0);
      exp_succ  <= 1'b0;
      exp_fail  <= 1'b0;
      done      <= 1'b0;
    end else begin
      exp_succ <= 1'b0;
      exp_fail <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          // A step arriving together with start is dropped: the first vector has not been shown yet.
          if (start) begin
            mode_q    <= start_mode;
            len_q     <= start_len;
            fail_q    <= fail_at;
            step_cnt  <= '0;
            busy      <= 1'b1;
            vld       <= 1'b1;
            c         <= start_vec.c;
            b         <= start_vec.b;
            viol_q    <= start_vec.viol;
            exp_state <= start_vec.st;
            state     <= start_close ? CLOSE : CHAIN;
          end
        end
        CHAIN: begin
          if (step) begin
            if (viol_q) begin
              exp_fail <= 1'b1;
              state    <= ABORT;
            end else begin
              step_cnt  <= cnt_nxt;
              c         <= next_vec.c;
              b         <= next_vec.b;
              viol_q    <= next_vec.viol;
              exp_state <= next_vec.st;
              state     <= close_nxt ? CLOSE : CHAIN;
            end
          end
        end
        CLOSE: begin
          if (step) begin
            if (viol_q) begin
              exp_fail <= 1'b1;
              state    <= ABORT;
            end else begin
              exp_succ <= 1'b1;
              state    <= DONE;
            end
          end
        end
        ABORT, DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          vld       <= 1'b0;
          c         <= 1'b0;
          b         <= 1'b0;
          viol_q    <= 1'b0;
          exp_state <= 32'(S0);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sva_seq_gen.sv
// Self-checking bench for sva_seq_gen: directed corner cases plus random sequences against a list model.
module tb_sva_seq_gen;
  import sva_seq_pkg::*;

  localparam int LEN_W  = 4;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              start;
  logic [1:0]        mode;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  fail_at;
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic              step;
  logic              busy, vld, c, b, exp_succ, exp_fail, done;
  logic [31:0]       exp_state;

  int errors = 0;
  int checks = 0;
  logic [LFSR_W-1:0] model_lfsr;

  typedef struct {
    logic c;
    logic b;
    int   st;
  } ev_t;
  ev_t exp_q[$];

  sva_seq_gen #(.LEN_W(LEN_W), .LFSR_W(LFSR_W), .LFSR_TAPS(TAPS)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .mode     (mode),
    .len      (len),
    .fail_at  (fail_at),
    .seed_load(seed_load),
    .seed     (seed),
    .step     (step),
    .busy     (busy),
    .vld      (vld),
    .c        (c),
    .b        (b),
    .exp_state(exp_state),
    .exp_succ (exp_succ),
    .exp_fail (exp_fail),
    .done     (done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  task automatic load_seed(input logic [LFSR_W-1:0] s);
    seed_load = 1'b1;
    seed      = s;
    tick();
    seed_load = 1'b0;
    model_lfsr = (s == '0) ? LFSR_W'(1) : s;
  endtask

  // Builds the expected vector list from the sequence rules, then walks the DUT through it.
  task automatic run_seq(input int m, input int l, input int fa, input bit with_step, input bit poke);
    int  eff_len;
    bit  ends_fail;
    int  gap;
    bit  last;
    ev_t e;
    eff_len   = (m == 3) ? int'(model_lfsr[LEN_W-1:0]) : l;
    if (m == 3) model_lfsr = lfsr_next(model_lfsr);
    ends_fail = 1'b0;
    exp_q.delete();
    if (m == 0) begin
      exp_q.push_back('{c: 1'b0, b: 1'b1, st: SEND});
    end else begin
      for (int i = 0; i < eff_len; i++) begin
        if (m == 2 && i == fa) begin
          exp_q.push_back('{c: 1'b0, b: 1'b0, st: S0});
          ends_fail = 1'b1;
          break;
        end
        exp_q.push_back('{c: 1'b1, b: 1'b0, st: S1});
      end
      if (!ends_fail) begin
        if (m == 2) begin
          exp_q.push_back('{c: 1'b0, b: 1'b0, st: S0});
          ends_fail = 1'b1;
        end else begin
          exp_q.push_back('{c: 1'b1, b: 1'b1, st: SEND});
        end
      end
    end

    start   = 1'b1;
    mode    = 2'(m);
    len     = LEN_W'(l);
    fail_at = LEN_W'(fa);
    step    = with_step;
    tick();
    start = 1'b0;
    step  = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);

    for (int k = 0; k < exp_q.size(); k++) begin
      e   = exp_q[k];
      gap = (poke && k == 0) ? 2 : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        if (poke && k == 0 && g == 0) begin
          start     = 1'b1;
          mode      = 2'd0;
          seed_load = 1'b1;
          seed      = 16'(($urandom_range(2, 65535)));
        end
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
      end
      check($sformatf("vld[%0d]", k), 32'(vld), 32'd1);
      check($sformatf("c[%0d]", k), 32'(c), 32'(e.c));
      check($sformatf("b[%0d]", k), 32'(b), 32'(e.b));
      check($sformatf("exp_state[%0d]", k), exp_state, 32'(e.st));
      step = 1'b1;
      tick();
      step = 1'b0;
      last = (k == exp_q.size() - 1);
      check($sformatf("exp_succ[%0d]", k), 32'(exp_succ), 32'(last && !ends_fail));
      check($sformatf("exp_fail[%0d]", k), 32'(exp_fail), 32'(last && ends_fail));
      check($sformatf("done_early[%0d]", k), 32'(done), 32'd0);
    end

    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("vld_end", 32'(vld), 32'd0);
    check("cb_end", {30'd0, c, b}, 32'd0);
    check("exp_state_end", exp_state, 32'(S0));
    tick();
    check("done_once", 32'(done), 32'd0);
  endtask

  initial begin
    sys_rst   = 1'b1;
    start     = 1'b0;
    mode      = 2'd0;
    len       = '0;
    fail_at   = '0;
    seed_load = 1'b0;
    seed      = '0;
    step      = 1'b0;
    model_lfsr = LFSR_W'(1);
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_cb", {30'd0, c, b}, 32'd0);
    check("rst_pulses", {29'd0, exp_succ, exp_fail, done}, 32'd0);
    check("rst_exp_state", exp_state, 32'(S0));
    @(negedge sys_clk);
    sys_rst = 1'b0;
    tick();

    // Direct pass, chain pass with an ignored start/seed_load, injected chain failure.
    run_seq(0, 0, 0, 1'b0, 1'b0);
    run_seq(1, 3, 0, 1'b0, 1'b1);
    run_seq(2, 5, 2, 1'b0, 1'b0);

    // Random length from the LFSR: zero seed becomes 1, then explicit seed 1 with a mid-run poke.
    load_seed(16'h0000);
    run_seq(3, 0, 0, 1'b0, 1'b0);
    load_seed(16'h0001);
    run_seq(3, 0, 0, 1'b0, 1'b1);
    run_seq(3, 0, 0, 1'b0, 1'b0);

    // Start and step together: step dropped, full chain still required.
    run_seq(1, 2, 0, 1'b1, 1'b0);

    // Boundaries: failure at the closing slot, zero lengths, longest chain, failure at index 0.
    run_seq(2, 3, 7, 1'b0, 1'b0);
    run_seq(2, 0, 0, 1'b0, 1'b0);
    run_seq(1, 0, 0, 1'b0, 1'b0);
    run_seq(1, 15, 0, 1'b0, 1'b0);
    run_seq(2, 4, 0, 1'b0, 1'b0);
    run_seq(2, 15, 15, 1'b0, 1'b0);

    // Reset in the middle of a chain: outputs clear at once and no pulse follows.
    start = 1'b1; mode = 2'd1; len = 4'd6; fail_at = '0;
    tick();
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_vld", 32'(vld), 32'd0);
    check("mid_rst_cb", {30'd0, c, b}, 32'd0);
    check("mid_rst_exp_state", exp_state, 32'(S0));
    model_lfsr = LFSR_W'(1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step = 1'b1;
      tick();
      check($sformatf("post_rst_quiet[%0d]", s), {29'd0, exp_succ, exp_fail, done}, 32'd0);
    end
    step = 1'b0;

    // Random sequences across all modes, including reseeding between runs.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 5) == 0) load_seed(16'($urandom_range(0, 65535)));
      run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
